fir_xifu_offload: RTL and testbench
===================================

# fir_xifu_offload

Core-side initiator for the FIR XIFU eXtension Interface channels: issue, commit and result. It takes instructions from a simple valid/ready request port and issues them to the coprocessor. It then sends the matching commit (or kill), tracks outstanding IDs in a scoreboard, and returns coprocessor results on a registered response port. It is used as the bench/SoC driver for the FIR coprocessor when no full CV32E40X core is present.

## Interface
- ID_W, 4, width of the instruction ID; the scoreboard has 2^ID_W entries.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous flush.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request ready.
- req_instr_i  in  32  instruction word.
- req_rs1_i  in  32  source operand 1.
- req_rs2_i  in  32  source operand 2.
- req_kill_i  in  1  commit this instruction as killed.
- issue_valid_o  out  1  issue request valid.
- issue_ready_i  in  1  coprocessor ready to take the issue.
- issue_instr_o  out  32  issued instruction word.
- issue_id_o  out  ID_W  issued instruction ID.
- issue_rs1_o  out  32  issued operand 1.
- issue_rs2_o  out  32  issued operand 2.
- issue_accept_i  in  1  coprocessor accepts the instruction (sampled at handshake).
- issue_writeback_i  in  1  coprocessor will produce a result (sampled at handshake).
- commit_valid_o  out  1  commit strobe, single cycle.
- commit_id_o  out  ID_W  ID being committed.
- commit_kill_o  out  1  kill flag for the committed ID.
- result_valid_i  in  1  result valid.
- result_ready_o  out  1  ready to take a result.
- result_id_i  in  ID_W  result ID.
- result_data_i  in  32  result data.
- result_rd_i  in  5  destination register.
- result_we_i  in  1  write enable.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_id_o  out  ID_W  response ID.
- rsp_data_o  out  32  response data.
- rsp_rd_o  out  5  response destination register.
- rsp_we_o  out  1  response write enable.
- reject_o  out  1  one-cycle pulse: issued instruction was not accepted.
- err_o  out  1  one-cycle pulse: a result arrived for an ID that is not pending.
- outstanding_o  out  ID_W+1  number of pending IDs (scoreboard popcount).

## Operation
- FSM states: IDLE, ISSUE, COMMIT.
- IDLE: req_ready_o = !scoreboard[next_id].
  - On request handshake, latch instr, rs1, rs2 and kill, then go to ISSUE.
- ISSUE: issue_valid_o = 1, with all issue outputs from the latched values and issue_id_o = next_id.
  - All issue outputs are held stable until issue_ready_i is seen.
  - On handshake, latch accept and writeback, then go to COMMIT.
- COMMIT: commit_valid_o = 1 for exactly one cycle.
  - commit_id_o = next_id; commit_kill_o = kill | !accept.
  - reject_o = !accept in the same cycle.
  - If accept & writeback & !kill, set scoreboard[next_id].
  - next_id increments modulo 2^ID_W (for accepted and rejected alike), then go to IDLE.
- Result path: result_ready_o = !rsp_valid_o | rsp_ready_i.
  - On result handshake with scoreboard[result_id_i] set: clear the bit and load the response register.
  - If the bit is not set (this includes a result arriving before its commit): drop the result and pulse err_o.
- Response register: rsp_valid_o stays high until rsp_ready_i.
- Scoreboard set and clear in the same cycle for different IDs both take effect. The same ID cannot be set and cleared in one cycle, because the bit is not yet set at the time of its own commit.
- ID wrap-around: a new request stalls while the next ID is still pending.
- clear_i: state goes to IDLE, the scoreboard clears, rsp_valid_o is dropped and next_id returns to 0.
  - This applies even in the middle of ISSUE; issue_valid_o drops the following cycle.

## Timing
- Reset values:
  - state IDLE, next_id 0, scoreboard 0.
  - All *_valid_o, reject_o and err_o are 0; all data outputs are 0.
  - req_ready_o = 1 and result_ready_o = 1.
- Issue latency:
  - Request handshake at cycle n gives issue_valid_o at n+1.
  - With issue_ready_i at n+1, commit_valid_o is at n+2.
  - req_ready_o is high again at n+3.
  - Peak throughput is 1 instruction per 3 cycles.
- Result to response: rsp_valid_o rises the cycle after the result handshake.
- Back-to-back results are sustained at 1 per cycle while rsp_ready_i = 1.
- outstanding_o reflects scoreboard changes one cycle after the event.

## Test plan
- Single instruction (instr 0x0000_100B, accept = 1, writeback = 1): issue_id_o = 0; commit at +2 with kill = 0; outstanding_o = 1. A result with id 0 and data 0xDEAD_BEEF gives rsp at +1 with the same data; outstanding_o returns to 0.
- Rejected issue (accept = 0): reject_o pulses in the COMMIT cycle, commit_kill_o = 1, outstanding_o stays 0, and the next request gets ID 1.
- req_kill_i = 1 with accept = 1: commit_kill_o = 1 and no scoreboard entry. A later result with that ID pulses err_o and no rsp is produced.
- Backpressure:
  - issue_ready_i held low for 5 cycles: issue outputs stay stable.
  - rsp_ready_i low: result_ready_o drops once the response register is full.
- ID wrap: with ID_W = 2, issue 4 writeback instructions and return no results. The 5th request sees req_ready_o = 0 until the result for ID 0 arrives; it is then issued with ID 0.
- clear_i asserted during ISSUE with 2 pending IDs: next cycle issue_valid_o = 0, outstanding_o = 0, next_id = 0 and req_ready_o = 1.

Source files
------------

// File: rtl/fir_xifu_offload.sv
// FIR XIFU offload initiator: issue, commit and result channels.
// Tracks outstanding instruction IDs in a scoreboard and registers responses.
module fir_xifu_offload #(
  parameter int ID_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_instr_i,
  input  logic [31:0]     req_rs1_i,
  input  logic [31:0]     req_rs2_i,
  input  logic            req_kill_i,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output logic [31:0]     issue_instr_o,
  output logic [ID_W-1:0] issue_id_o,
  output logic [31:0]     issue_rs1_o,
  output logic [31:0]     issue_rs2_o,
  input  logic            issue_accept_i,
  input  logic            issue_writeback_i,
  output logic            commit_valid_o,
  output logic [ID_W-1:0] commit_id_o,
  output logic            commit_kill_o,
  input  logic            result_valid_i,
  output logic            result_ready_o,
  input  logic [ID_W-1:0] result_id_i,
  input  logic [31:0]     result_data_i,
  input  logic [4:0]      result_rd_i,
  input  logic            result_we_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [ID_W-1:0] rsp_id_o,
  output logic [31:0]     rsp_data_o,
  output logic [4:0]      rsp_rd_o,
  output logic            rsp_we_o,
  output logic            reject_o,
  output logic            err_o,
  output logic [ID_W:0]   outstanding_o
);

  localparam int N = 1 << ID_W;

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;

  state_t          state;
  logic [ID_W-1:0] next_id;
  logic [N-1:0]    sb;
  logic [N-1:0]    sb_set;
  logic [N-1:0]    sb_clr;
  logic [31:0]     instr_q;
  logic [31:0]     rs1_q;
  logic [31:0]     rs2_q;
  logic            kill_q;
  logic            acc_q;
  logic            wb_q;
  logic            req_hs;
  logic            res_hs;
  logic            res_hit;
  logic [ID_W:0]   cnt;

  assign req_ready_o    = (state == IDLE) && !sb[next_id];
  assign req_hs         = req_valid_i && req_ready_o;
  assign issue_valid_o  = (state == ISSUE);
  assign issue_instr_o  = instr_q;
  assign issue_rs1_o    = rs1_q;
  assign issue_rs2_o    = rs2_q;
  assign issue_id_o     = next_id;
  assign commit_valid_o = (state == COMMIT);
  assign commit_id_o    = next_id;
  assign commit_kill_o  = commit_valid_o && (kill_q || !acc_q);
  assign reject_o       = commit_valid_o && !acc_q;
  assign result_ready_o = !rsp_valid_o || rsp_ready_i;
  assign res_hs         = result_valid_i && result_ready_o;
  assign res_hit        = res_hs && sb[result_id_i];

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (commit_valid_o && acc_q && wb_q && !kill_q)
      sb_set[next_id] = 1'b1;
    if (res_hit)
      sb_clr[result_id_i] = 1'b1;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++)
      cnt = cnt + {{ID_W{1'b0}}, sb[i]};
  end

  assign outstanding_o = cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      next_id <= '0;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      kill_q  <= 1'b0;
      acc_q   <= 1'b0;
      wb_q    <= 1'b0;
    end else if (clear_i) begin
      state   <= IDLE;
      next_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_hs) begin
            instr_q <= req_instr_i;
            rs1_q   <= req_rs1_i;
            rs2_q   <= req_rs2_i;
            kill_q  <= req_kill_i;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready_i) begin
            acc_q <= issue_accept_i;
            wb_q  <= issue_writeback_i;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          next_id <= next_id + ID_W'(1);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set and clear never hit the same ID in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      sb <= '0;
    else if (clear_i)
      sb <= '0;
    else
      sb <= (sb | sb_set) & ~sb_clr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_rd_o    <= '0;
      rsp_we_o    <= 1'b0;
      err_o       <= 1'b0;
    end else if (clear_i) begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= res_hs && !sb[result_id_i];
      if (res_hit) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= result_id_i;
        rsp_data_o  <= result_data_i;
        rsp_rd_o    <= result_rd_i;
        rsp_we_o    <= result_we_i;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_xifu_offload.sv
// Directed bench for fir_xifu_offload with a 2-bit ID space.
// Table of single-instruction vectors plus hand-written multi-cycle sequences.
module tb_fir_xifu_offload;

  localparam int ID_W = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            clear_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [31:0]     req_instr_i;
  logic [31:0]     req_rs1_i;
  logic [31:0]     req_rs2_i;
  logic            req_kill_i;
  logic            issue_valid_o;
  logic            issue_ready_i;
  logic [31:0]     issue_instr_o;
  logic [ID_W-1:0] issue_id_o;
  logic [31:0]     issue_rs1_o;
  logic [31:0]     issue_rs2_o;
  logic            issue_accept_i;
  logic            issue_writeback_i;
  logic            commit_valid_o;
  logic [ID_W-1:0] commit_id_o;
  logic            commit_kill_o;
  logic            result_valid_i;
  logic            result_ready_o;
  logic [ID_W-1:0] result_id_i;
  logic [31:0]     result_data_i;
  logic [4:0]      result_rd_i;
  logic            result_we_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [ID_W-1:0] rsp_id_o;
  logic [31:0]     rsp_data_o;
  logic [4:0]      rsp_rd_o;
  logic            rsp_we_o;
  logic            reject_o;
  logic            err_o;
  logic [ID_W:0]   outstanding_o;

  fir_xifu_offload #(.ID_W(ID_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_instr_i(req_instr_i), .req_rs1_i(req_rs1_i),
    .req_rs2_i(req_rs2_i), .req_kill_i(req_kill_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_id_o(issue_id_o),
    .issue_rs1_o(issue_rs1_o), .issue_rs2_o(issue_rs2_o),
    .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
    .commit_kill_o(commit_kill_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_data_i(result_data_i),
    .result_rd_i(result_rd_i), .result_we_i(result_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_rd_o(rsp_rd_o), .rsp_we_o(rsp_we_o),
    .reject_o(reject_o), .err_o(err_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        acc;
    logic        wb;
    logic [1:0]  id;
    logic        ekill;
    logic        erej;
    logic [2:0]  eout;
  } vec_t;

  vec_t tbl [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_result(input logic [1:0] id, input logic [31:0] d,
                             input logic [4:0] rd);
    result_valid_i = 1'b1;
    result_id_i    = id;
    result_data_i  = d;
    result_rd_i    = rd;
    result_we_i    = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the commit cycle.
  task automatic issue_one(input vec_t v, input int stall);
    int n;
    req_valid_i = 1'b1;
    req_instr_i = v.instr;
    req_rs1_i   = v.rs1;
    req_rs2_i   = v.rs2;
    req_kill_i  = v.kill;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      chk("issue_valid", {31'd0, issue_valid_o}, 32'd1);
      chk("issue_id", {30'd0, issue_id_o}, {30'd0, v.id});
      chk("issue_instr", issue_instr_o, v.instr);
      chk("issue_rs1", issue_rs1_o, v.rs1);
      chk("issue_rs2", issue_rs2_o, v.rs2);
      if (s < stall) @(negedge clk_i);
    end
    issue_ready_i     = 1'b1;
    issue_accept_i    = v.acc;
    issue_writeback_i = v.wb;
    @(negedge clk_i);
    issue_ready_i     = 1'b0;
    issue_accept_i    = 1'b0;
    issue_writeback_i = 1'b0;
    chk("commit_valid", {31'd0, commit_valid_o}, 32'd1);
    chk("commit_id", {30'd0, commit_id_o}, {30'd0, v.id});
    chk("commit_kill", {31'd0, commit_kill_o}, {31'd0, v.ekill});
    chk("reject", {31'd0, reject_o}, {31'd0, v.erej});
    @(negedge clk_i);
    chk("commit_drop", {31'd0, commit_valid_o}, 32'd0);
    chk("reject_drop", {31'd0, reject_o}, 32'd0);
    chk("outstanding", {29'd0, outstanding_o}, {29'd0, v.eout});
  endtask

  initial begin
    tbl[0] = '{32'h0000_100B, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1,
               2'd0, 1'b0, 1'b0, 3'd1};
    tbl[1] = '{32'h0000_200B, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1,
               2'd1, 1'b1, 1'b1, 3'd1};
    tbl[2] = '{32'h0000_300B, 32'h55, 32'h66, 1'b1, 1'b1, 1'b1,
               2'd2, 1'b1, 1'b0, 3'd1};
    tbl[3] = '{32'h0000_400B, 32'h77, 32'h88, 1'b0, 1'b1, 1'b0,
               2'd3, 1'b0, 1'b0, 3'd1};

    rst_i = 1'b1;
    clear_i = 1'b0;
    req_valid_i = 1'b0;
    req_instr_i = '0;
    req_rs1_i = '0;
    req_rs2_i = '0;
    req_kill_i = 1'b0;
    issue_ready_i = 1'b0;
    issue_accept_i = 1'b0;
    issue_writeback_i = 1'b0;
    result_valid_i = 1'b0;
    result_id_i = '0;
    result_data_i = '0;
    result_rd_i = '0;
    result_we_i = 1'b0;
    rsp_ready_i = 1'b1;

    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_res_ready", {31'd0, result_ready_o}, 32'd1);
    chk("rst_issue_valid", {31'd0, issue_valid_o}, 32'd0);
    chk("rst_commit_valid", {31'd0, commit_valid_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_reject", {31'd0, reject_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_issue_instr", issue_instr_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++)
      issue_one(tbl[i], 0);

    // Result for id 0 returns on the response port one cycle later.
    send_result(2'd0, 32'hDEAD_BEEF, 5'd5);
    chk("res_ready", {31'd0, result_ready_o}, 32'd1);
    @(negedge clk_i);
    result_valid_i = 1'b0;
    chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("rsp_data", rsp_data_o, 32'hDEAD_BEEF);
    chk("rsp_id", {30'd0, rsp_id_o}, 32'd0);
    chk("rsp_rd", {27'd0, rsp_rd_o}, 32'd5);
    chk("rsp_we", {31'd0, rsp_we_o}, 32'd1);
    chk("out_after_res", {29'd0, outstanding_o}, 32'd0);
    @(negedge clk_i);
    chk("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);

    // Result for the killed id 2 is dropped with an error pulse.
    send_result(2'd2, 32'h0BAD_0BAD, 5'd7);
    @(negedge clk_i);
    result_valid_i = 1'b0;
    chk("err_pulse", {31'd0, err_o}, 32'd1);
    chk("err_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    @(negedge clk_i);
    chk("err_drop", {31'd0, err_o}, 32'd0);

    // Issue backpressure: hold issue_ready low for 5 cycles.
    issue_one('{32'h0000_500B, 32'hAAAA, 32'hBBBB, 1'b0, 1'b1, 1'b1,
                2'd0, 1'b0, 1'b0, 3'd1}, 5);
    issue_one('{32'h0000_600B, 32'hCCCC, 32'hDDDD, 1'b0, 1'b1, 1'b1,
                2'd1, 1'b0, 1'b0, 3'd2}, 0);

    // Response backpressure.
    rsp_ready_i = 1'b0;
    send_result(2'd0, 32'h1234_5678, 5'd3);
    @(negedge clk_i);
    chk("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("bp_res_ready", {31'd0, result_ready_o}, 32'd0);
    chk("bp_rsp_data", rsp_data_o, 32'h1234_5678);
    send_result(2'd1, 32'h9ABC_DEF0, 5'd4);
    @(negedge clk_i);
    chk("bp_hold_data", rsp_data_o, 32'h1234_5678);
    chk("bp_hold_out", {29'd0, outstanding_o}, 32'd1);
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_res_ready_up", {31'd0, result_ready_o}, 32'd1);
    @(negedge clk_i);
    result_valid_i = 1'b0;
    chk("bp_rsp_data2", rsp_data_o, 32'h9ABC_DEF0);
    chk("bp_rsp_id2", {30'd0, rsp_id_o}, 32'd1);
    chk("bp_out0", {29'd0, outstanding_o}, 32'd0);
    @(negedge clk_i);
    chk("bp_rsp_drop", {31'd0, rsp_valid_o}, 32'd0);

    // Flush in IDLE restarts the ID sequence at 0.
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_issue_id", {30'd0, issue_id_o}, 32'd0);
    chk("clr_req_ready", {31'd0, req_ready_o}, 32'd1);

    // Wrap: fill all four IDs, then a fifth request must stall.
    for (int k = 0; k < 4; k++)
      issue_one('{32'h0000_700B + k, 32'(k), 32'(k + 8), 1'b0, 1'b1, 1'b1,
                  2'(k), 1'b0, 1'b0, 3'(k + 1)}, 0);
    req_valid_i = 1'b1;
    req_instr_i = 32'h0000_800B;
    req_rs1_i   = 32'h80;
    req_rs2_i   = 32'h81;
    req_kill_i  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("wrap_stall", {31'd0, req_ready_o}, 32'd0);
      @(negedge clk_i);
    end
    chk("wrap_no_issue", {31'd0, issue_valid_o}, 32'd0);
    send_result(2'd0, 32'h0000_00A0, 5'd1);
    @(negedge clk_i);
    result_valid_i = 1'b0;
    chk("wrap_ready", {31'd0, req_ready_o}, 32'd1);
    chk("wrap_out3", {29'd0, outstanding_o}, 32'd3);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("wrap_issue_valid", {31'd0, issue_valid_o}, 32'd1);
    chk("wrap_issue_id", {30'd0, issue_id_o}, 32'd0);
    chk("wrap_issue_instr", issue_instr_o, 32'h0000_800B);

    // Flush in the middle of ISSUE with two IDs pending.
    rsp_ready_i = 1'b0;
    send_result(2'd1, 32'h0000_00A1, 5'd2);
    @(negedge clk_i);
    result_valid_i = 1'b0;
    chk("mid_out2", {29'd0, outstanding_o}, 32'd2);
    chk("mid_issue_held", {31'd0, issue_valid_o}, 32'd1);
    chk("mid_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    rsp_ready_i = 1'b1;
    chk("flush_issue_valid", {31'd0, issue_valid_o}, 32'd0);
    chk("flush_out", {29'd0, outstanding_o}, 32'd0);
    chk("flush_next_id", {30'd0, issue_id_o}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("flush_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    issue_one('{32'h0000_900B, 32'h90, 32'h91, 1'b0, 1'b1, 1'b1,
                2'd0, 1'b0, 1'b0, 3'd1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
